// File: rtl/blk_sync_gen_if.sv
// Pixel-stream bundle between the video input stage, the block-grid timing
// generator and the block-statistics buffer.
interface blk_sync_gen_if #(
    parameter int DATA_W = 24,
    parameter int HBLKS  = 10,
    parameter int VBLKS  = 10
);
    localparam int BXW = (HBLKS > 1) ? $clog2(HBLKS) : 1;
    localparam int BYW = (VBLKS > 1) ? $clog2(VBLKS) : 1;

    logic              vs_i;
    logic              de_i;
    logic [DATA_W-1:0] wd_i;
    logic              de_o;
    logic [DATA_W-1:0] wd_o;
    logic              h_save_o;
    logic              v_save_o;
    logic [BXW-1:0]    bx_o;
    logic [BYW-1:0]    by_o;
    logic              fmt_err_o;

    modport slave (
        input  vs_i, de_i, wd_i,
        output de_o, wd_o, h_save_o, v_save_o, bx_o, by_o, fmt_err_o
    );

    modport master (
        output vs_i, de_i, wd_i,
        input  de_o, wd_o, h_save_o, v_save_o, bx_o, by_o, fmt_err_o
    );
endinterface

// File: rtl/blk_sync_gen.sv
// Block-grid timing generator: tracks pixel/line position in a DE/VS stream and
// emits block-start (h_save) and block-row-advance (v_save) strobes.
module blk_sync_gen #(
    parameter int H_ACTIVE = 1920,
    parameter int V_ACTIVE = 1080,
    parameter int HBLKS    = 10,
    parameter int VBLKS    = 10,
    parameter int DATA_W   = 24
) (
    input  logic          clk_i,
    input  logic          rst_i,
    blk_sync_gen_if.slave bus
);
    localparam int BW    = H_ACTIVE / HBLKS;
    localparam int BH    = V_ACTIVE / VBLKS;
    localparam int BXW   = (HBLKS > 1) ? $clog2(HBLKS) : 1;
    localparam int BYW   = (VBLKS > 1) ? $clog2(VBLKS) : 1;
    localparam int COLW  = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int PXW   = (BW > 1) ? $clog2(BW) : 1;
    localparam int LNW   = (BH > 1) ? $clog2(BH) : 1;
    localparam int LINEW = $clog2(V_ACTIVE + 1);

    localparam logic [COLW-1:0]  COL_LAST = COLW'(H_ACTIVE - 1);
    localparam logic [PXW-1:0]   PX_LAST  = PXW'(BW - 1);
    localparam logic [LNW-1:0]   LN_LAST  = LNW'(BH - 1);
    localparam logic [BYW-1:0]   BY_LAST  = BYW'(VBLKS - 1);
    localparam logic [LINEW-1:0] LINE_END = LINEW'(V_ACTIVE);

    logic [COLW-1:0]   col_q, col_d;
    logic [PXW-1:0]    px_q, px_d;
    logic [BXW-1:0]    bx_q, bx_d;
    logic [LINEW-1:0]  line_q, line_d;
    logic [LNW-1:0]    ln_q, ln_d;
    logic [BYW-1:0]    by_q, by_d;
    logic              full_q, full_d;
    logic              act_q, vs_q, blk_q, blk_d;
    logic              vpend_q, vpend_d;
    logic              err_q, err_d;
    logic              hs_q, hs_d, vsv_q;
    logic              de_o_q;
    logic [DATA_W-1:0] wd_o_q;
    logic [BXW-1:0]    bxo_q, bxo_d;
    logic [BYW-1:0]    byo_q, byo_d;

    logic vs_rise, de_eff, fall;

    // blk_q masks the remainder of a line that was cut by reset until DE drops.
    always_comb begin
        vs_rise = bus.vs_i & ~vs_q;
        de_eff  = bus.de_i & ~blk_q;
        fall    = act_q & ~de_eff;
        blk_d   = blk_q & bus.de_i;
        col_d   = col_q;
        px_d    = px_q;
        bx_d    = bx_q;
        line_d  = line_q;
        ln_d    = ln_q;
        by_d    = by_q;
        full_d  = full_q;
        vpend_d = 1'b0;
        err_d   = err_q;
        hs_d    = 1'b0;
        bxo_d   = bxo_q;
        byo_d   = byo_q;

        if (de_eff) begin
            bxo_d = bx_q;
            byo_d = by_q;
            if (full_q) begin
                err_d = 1'b1;
            end else begin
                hs_d = (px_q == '0);
                if (col_q == COL_LAST) begin
                    full_d = 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                    if (px_q == PX_LAST) begin
                        px_d = '0;
                        bx_d = bx_q + 1'b1;
                    end else begin
                        px_d = px_q + 1'b1;
                    end
                end
            end
        end

        if (fall) begin
            if (!full_q) err_d = 1'b1;
            col_d  = '0;
            px_d   = '0;
            bx_d   = '0;
            full_d = 1'b0;
            if (line_q != '1) line_d = line_q + 1'b1;
            if (ln_q == LN_LAST) begin
                ln_d    = '0;
                by_d    = (by_q == BY_LAST) ? '0 : by_q + 1'b1;
                vpend_d = 1'b1;
            end else begin
                ln_d = ln_q + 1'b1;
            end
        end

        // Frame start wins over a coincident end of line.
        if (vs_rise) begin
            if (line_q != '0 && line_q != LINE_END) err_d = 1'b1;
            col_d   = '0;
            px_d    = '0;
            bx_d    = '0;
            full_d  = 1'b0;
            line_d  = '0;
            ln_d    = '0;
            by_d    = '0;
            vpend_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            col_q   <= '0;
            px_q    <= '0;
            bx_q    <= '0;
            line_q  <= '0;
            ln_q    <= '0;
            by_q    <= '0;
            full_q  <= 1'b0;
            act_q   <= 1'b0;
            vs_q    <= 1'b0;
            blk_q   <= bus.de_i;
            vpend_q <= 1'b0;
            err_q   <= 1'b0;
            hs_q    <= 1'b0;
            vsv_q   <= 1'b0;
            de_o_q  <= 1'b0;
            wd_o_q  <= '0;
            bxo_q   <= '0;
            byo_q   <= '0;
        end else begin
            col_q   <= col_d;
            px_q    <= px_d;
            bx_q    <= bx_d;
            line_q  <= line_d;
            ln_q    <= ln_d;
            by_q    <= by_d;
            full_q  <= full_d;
            act_q   <= de_eff;
            vs_q    <= bus.vs_i;
            blk_q   <= blk_d;
            vpend_q <= vpend_d;
            err_q   <= err_d;
            hs_q    <= hs_d;
            vsv_q   <= vpend_q;
            de_o_q  <= bus.de_i;
            wd_o_q  <= bus.wd_i;
            bxo_q   <= bxo_d;
            byo_q   <= byo_d;
        end
    end

    assign bus.de_o      = de_o_q;
    assign bus.wd_o      = wd_o_q;
    assign bus.h_save_o  = hs_q;
    assign bus.v_save_o  = vsv_q;
    assign bus.bx_o      = bxo_q;
    assign bus.by_o      = byo_q;
    assign bus.fmt_err_o = err_q;
endmodule

// File: tb/tb_blk_sync_gen.sv
// Scoreboard bench for blk_sync_gen on a 40x20 frame split into 4x2 blocks.
module tb_blk_sync_gen;
    localparam int H  = 40;
    localparam int V  = 20;
    localparam int HB = 4;
    localparam int VB = 2;
    localparam int BW = 10;
    localparam int DW = 24;

    typedef struct packed {
        logic [23:0] wd;
        logic        hs;
        logic [1:0]  bx;
        logic        by;
    } pix_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    blk_sync_gen_if #(.DATA_W(DW), .HBLKS(HB), .VBLKS(VB)) bus ();

    blk_sync_gen #(
        .H_ACTIVE(H), .V_ACTIVE(V), .HBLKS(HB), .VBLKS(VB), .DATA_W(DW)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    pix_t pq[$];
    int   vq[$];
    int   errors = 0;
    int   checks = 0;
    int   tcyc   = 0;
    int   mcyc   = 0;
    bit   done   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, mcyc);
        end
    endtask

    // Inputs change 1 time unit after the edge; the monitor samples on negedges.
    task automatic step(input logic r, input logic vs, input logic de, input logic [23:0] wd);
        @(posedge clk);
        tcyc++;
        #1;
        rst      = r;
        bus.vs_i = vs;
        bus.de_i = de;
        bus.wd_i = wd;
    endtask

    task automatic blank(input int n, input bit vexp);
        for (int b = 0; b < n; b++) begin
            step(1'b0, 1'b0, 1'b0, 24'h0);
            if (b == 0 && vexp) vq.push_back(tcyc + 2);
        end
    endtask

    task automatic line(input int npix, input int tag, input logic by, input bit vexp);
        for (int c = 0; c < npix; c++) begin
            pix_t p;
            p.wd = {8'(tag), 8'(c), 8'h5A};
            p.hs = (c < H) && (c % BW == 0);
            p.bx = (c < H) ? 2'(c / BW) : 2'd3;
            p.by = by;
            pq.push_back(p);
            step(1'b0, 1'b0, 1'b1, p.wd);
        end
        blank(10, vexp);
    endtask

    task automatic lines(input int first, input int n, input int tag);
        for (int i = first; i < first + n; i++)
            line(H, tag + i, 1'((i / 10) % 2), (i % 10) == 9);
    endtask

    task automatic vs_pulse();
        step(1'b0, 1'b1, 1'b0, 24'h0);
        step(1'b0, 1'b1, 1'b0, 24'h0);
        step(1'b0, 1'b0, 1'b0, 24'h0);
        step(1'b0, 1'b0, 1'b0, 24'h0);
    endtask

    task automatic reset_chk(input string name);
        step(1'b1, 1'b0, 1'b0, 24'hFFFFFF);
        step(1'b1, 1'b0, 1'b0, 24'hFFFFFF);
        step(1'b0, 1'b0, 1'b0, 24'h0);
        @(negedge clk);
        chk(name, {bus.de_o, bus.wd_o, bus.h_save_o, bus.v_save_o, bus.bx_o, bus.by_o, bus.fmt_err_o}, 32'h0);
    endtask

    task automatic err_chk(input string name, input logic exp);
        @(negedge clk);
        chk(name, 32'(bus.fmt_err_o), 32'(exp));
    endtask

    always @(negedge clk) begin
        mcyc++;
        if (!done) begin
            if (bus.de_o) begin
                if (pq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pixel_unexpected: got wd_o=%0h with empty queue (cycle %0d)", bus.wd_o, mcyc);
                end else begin
                    pix_t e;
                    e = pq.pop_front();
                    chk("pixel", 32'({bus.wd_o, bus.h_save_o, bus.bx_o, bus.by_o}), 32'(e));
                end
            end else begin
                chk("hsave_without_de", 32'(bus.h_save_o), 32'h0);
            end
            chk("hsave_vsave_overlap", 32'(bus.h_save_o & bus.v_save_o), 32'h0);
            if (bus.v_save_o) begin
                if (vq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL vsave_unexpected: got pulse at cycle %0d required none", mcyc);
                end else begin
                    chk("vsave_cycle", 32'(mcyc), 32'(vq.pop_front()));
                end
            end else if (vq.size() > 0 && mcyc > vq[0]) begin
                checks++;
                errors++;
                $display("FAIL vsave_missing: got none required pulse at cycle %0d", vq.pop_front());
            end
        end
    end

    initial begin
        bus.vs_i = 1'b0;
        bus.de_i = 1'b0;
        bus.wd_i = '0;

        // Nominal frame, then a second frame start on a complete frame
        reset_chk("reset_initial");
        vs_pulse();
        lines(0, 20, 0);
        err_chk("err_nominal_frame", 1'b0);
        vs_pulse();
        err_chk("err_vs_full_frame", 1'b0);
        lines(0, 2, 32);

        // Long line
        reset_chk("reset_before_long");
        vs_pulse();
        line(45, 64, 1'b0, 1'b0);
        err_chk("err_long_line", 1'b1);
        line(H, 65, 1'b0, 1'b0);

        // Short line still counts as line 0 of the block row
        reset_chk("reset_before_short");
        vs_pulse();
        line(35, 80, 1'b0, 1'b0);
        err_chk("err_short_line", 1'b1);
        lines(1, 9, 80);

        // Early frame start after 7 lines
        reset_chk("reset_before_early_vs");
        vs_pulse();
        lines(0, 7, 96);
        err_chk("err_before_early_vs", 1'b0);
        vs_pulse();
        err_chk("err_early_vs", 1'b1);
        lines(0, 11, 112);

        // Reset at column 17 of line 5
        reset_chk("reset_before_midline");
        vs_pulse();
        lines(0, 5, 128);
        for (int c = 0; c < H; c++) begin
            pix_t p;
            p.wd = {8'd200, 8'(c), 8'h5A};
            p.hs = (c < 17) && (c % BW == 0);
            p.bx = (c < 17) ? 2'(c / BW) : 2'd0;
            p.by = 1'b0;
            if (c == 17) begin
                step(1'b1, 1'b0, 1'b1, p.wd);
            end else begin
                pq.push_back(p);
                step(1'b0, 1'b0, 1'b1, p.wd);
            end
            if (c == 18) begin
                @(negedge clk);
                chk("midline_reset_outputs",
                    {bus.de_o, bus.wd_o, bus.h_save_o, bus.v_save_o, bus.bx_o, bus.by_o, bus.fmt_err_o},
                    32'h0);
            end
        end
        blank(10, 1'b0);
        lines(0, 10, 140);
        err_chk("err_after_midline", 1'b0);

        blank(6, 1'b0);
        @(negedge clk);
        chk("pixel_queue_drained", 32'(pq.size()), 32'h0);
        chk("vsave_queue_drained", 32'(vq.size()), 32'h0);
        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
